sdram_port_arbiter: RTL

//  Shares one 16-bit SDRAM controller channel (addr/din/req/rnw/udqm_n/ldqm_n in, dout/ready out)

---
 rtl/sdram_port_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter sharing one SDRAM controller channel between CPU, sound CPU and loader.
// One transaction at a time: grant, single-cycle m_req, wait for m_ready (or watchdog), ack owner.
module sdram_port_arbiter #(
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        init,
  input  logic [25:0] p0_addr,
  input  logic [15:0] p0_din,
  input  logic        p0_rnw,
  input  logic [1:0]  p0_be_n,
  input  logic        p0_req,
  output logic        p0_ack,
  output logic [15:0] p0_dout,
  input  logic [25:0] p1_addr,
  input  logic [15:0] p1_din,
  input  logic        p1_rnw,
  input  logic [1:0]  p1_be_n,
  input  logic        p1_req,
  output logic        p1_ack,
  output logic [15:0] p1_dout,
  input  logic [25:0] p2_addr,
  input  logic [15:0] p2_din,
  input  logic        p2_rnw,
  input  logic [1:0]  p2_be_n,
  input  logic        p2_req,
  output logic        p2_ack,
  output logic [15:0] p2_dout,
  output logic [25:0] m_addr,
  output logic [15:0] m_din,
  output logic        m_rnw,
  output logic        m_udqm_n,
  output logic        m_ldqm_n,
  output logic        m_req,
  input  logic [15:0] m_dout,
  input  logic        m_ready,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Watchdog value on the last WAIT cycle before forced completion.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [1:0]  owner_reg;
  logic [1:0]  rr_last_reg;
  logic [7:0]  wd_reg;
  logic [25:0] m_addr_reg;
  logic [15:0] m_din_reg;
  logic        m_rnw_reg;
  logic        m_udqm_reg;
  logic        m_ldqm_reg;
  logic        m_req_reg;
  logic        busy_reg;
  logic        timeout_err_reg;

  logic [25:0] addr_a [3];
  logic [15:0] din_a  [3];
  logic [1:0]  be_a   [3];
  logic [2:0]  rnw_v;
  logic [2:0]  req_v;

  assign addr_a[0] = p0_addr;
  assign addr_a[1] = p1_addr;
  assign addr_a[2] = p2_addr;
  assign din_a[0]  = p0_din;
  assign din_a[1]  = p1_din;
  assign din_a[2]  = p2_din;
  assign be_a[0]   = p0_be_n;
  assign be_a[1]   = p1_be_n;
  assign be_a[2]   = p2_be_n;
  assign rnw_v     = {p2_rnw, p1_rnw, p0_rnw};
  assign req_v     = {p2_req, p1_req, p0_req};

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [1:0] search_order [3];
  logic [1:0] grant_idx;
  logic       grant_any;
  logic       complete;

  // Fixed priority is round-robin with the search always starting at port0.
  always_comb begin
    search_order[0] = (RR_MODE != 0) ? next_port(rr_last_reg) : 2'd0;
    search_order[1] = next_port(search_order[0]);
    search_order[2] = next_port(search_order[1]);
    grant_any       = |req_v;
    grant_idx       = search_order[2];
    for (int i = 2; i >= 0; i--) begin
      if (req_v[search_order[i]]) begin
        grant_idx = search_order[i];
      end
    end
  end

  // m_ready beats a simultaneous watchdog expiry.
  assign complete = (state_reg == WAIT) && (m_ready || (wd_reg == WD_LAST));

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_reg       <= IDLE;
      owner_reg       <= 2'd0;
      rr_last_reg     <= 2'd2;
      wd_reg          <= 8'd0;
      m_addr_reg      <= 26'd0;
      m_din_reg       <= 16'd0;
      m_rnw_reg       <= 1'b1;
      m_udqm_reg      <= 1'b0;
      m_ldqm_reg      <= 1'b0;
      m_req_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      m_req_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            owner_reg  <= grant_idx;
            m_addr_reg <= addr_a[grant_idx];
            m_din_reg  <= din_a[grant_idx];
            m_rnw_reg  <= rnw_v[grant_idx];
            m_udqm_reg <= rnw_v[grant_idx] ? 1'b0 : be_a[grant_idx][1];
            m_ldqm_reg <= rnw_v[grant_idx] ? 1'b0 : be_a[grant_idx][0];
            m_req_reg  <= 1'b1;
            wd_reg     <= 8'd0;
            busy_reg   <= 1'b1;
            state_reg  <= WAIT;
          end
        end
        WAIT: begin
          wd_reg <= wd_reg + 8'd1;
          if (complete) begin
            state_reg <= HOLD;
            if (!m_ready) begin
              timeout_err_reg <= 1'b1;
            end
            if (RR_MODE != 0) begin
              rr_last_reg <= owner_reg;
            end
          end
        end
        HOLD: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Per-port completion strobe and read-data register; writes leave dout untouched.
  for (genvar gi = 0; gi < 3; gi++) begin : g_port
    logic        ack_reg;
    logic [15:0] dout_reg;
    logic        owned;

    assign owned = (owner_reg == 2'(gi));

    always_ff @(posedge clk or posedge init) begin
      if (init) begin
        ack_reg  <= 1'b0;
        dout_reg <= 16'd0;
      end else begin
        ack_reg <= complete && owned;
        if (complete && owned && m_rnw_reg) begin
          dout_reg <= m_ready ? m_dout : 16'hFFFF;
        end
      end
    end
  end

  assign p0_ack      = g_port[0].ack_reg;
  assign p1_ack      = g_port[1].ack_reg;
  assign p2_ack      = g_port[2].ack_reg;
  assign p0_dout     = g_port[0].dout_reg;
  assign p1_dout     = g_port[1].dout_reg;
  assign p2_dout     = g_port[2].dout_reg;
  assign m_addr      = m_addr_reg;
  assign m_din       = m_din_reg;
  assign m_rnw       = m_rnw_reg;
  assign m_udqm_n    = m_udqm_reg;
  assign m_ldqm_n    = m_ldqm_reg;
  assign m_req       = m_req_reg;
  assign busy        = busy_reg;
  assign timeout_err = timeout_err_reg;

endmodule
